// File: rtl/me_pkg.sv
// Shared widths and state encoding for the motion-estimation job sequencer.
package me_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_TB, S_LOAD_SW, S_REQ, S_REL, S_DECODE, S_OUT
  } state_t;

  function automatic int addr_w(input int len);
    return $clog2(len * len);
  endfunction

  function automatic int cnt_w(input int tb_len, input int sw_len);
    return $clog2((sw_len - tb_len + 1) * (sw_len - tb_len + 1));
  endfunction

  function automatic int sad_w(input int tb_len, input int pe_w);
    return $clog2(tb_len * tb_len) + pe_w;
  endfunction

  function automatic int mv_w(input int tb_len, input int sw_len);
    return $clog2(sw_len - tb_len + 1) + 1;
  endfunction

endpackage

// File: rtl/mvec_decode.sv
// Sequential split of a row-major candidate index into signed (dx, dy)
// offsets around the window centre; one restoring subtract per cycle.
module mvec_decode
  import me_pkg::*;
#(
  parameter int  TB_LENGTH = 16,
  parameter int  SW_LENGTH = 64,
  localparam int CNT_WIDTH = cnt_w(TB_LENGTH, SW_LENGTH),
  localparam int MV_WIDTH  = mv_w(TB_LENGTH, SW_LENGTH)
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_go,
  input  logic [CNT_WIDTH-1:0]       i_mvec,
  output logic                       o_done,
  output logic signed [MV_WIDTH-1:0] o_dx,
  output logic signed [MV_WIDTH-1:0] o_dy
);

  localparam int R  = SW_LENGTH - TB_LENGTH + 1;
  localparam int RW = MV_WIDTH - 1;
  localparam logic [CNT_WIDTH-1:0]       R_C = CNT_WIDTH'(R);
  localparam logic signed [MV_WIDTH-1:0] OFS = MV_WIDTH'((R - 1) / 2);

  logic                 r_act;
  logic [CNT_WIDTH-1:0] r_rem;
  logic [RW-1:0]        r_row;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_act <= 1'b0;
      r_rem <= '0;
      r_row <= '0;
    end else if (i_go) begin
      r_act <= 1'b1;
      r_rem <= i_mvec;
      r_row <= '0;
    end else if (r_act) begin
      if (r_rem >= R_C) begin
        r_rem <= r_rem - R_C;
        r_row <= r_row + RW'(1);
      end else begin
        r_act <= 1'b0;
      end
    end
  end

  // Once rem < R it fits in RW bits, so the low slice is the column.
  assign o_done = r_act && (r_rem < R_C);
  assign o_dx   = $signed({1'b0, r_rem[RW-1:0]}) - OFS;
  assign o_dy   = $signed({1'b0, r_row}) - OFS;

endmodule

// File: rtl/me_job_ctrl.sv
// Job sequencer in front of me_top: streams TB then SW pixels into the
// pixel memories, handshakes the search, decodes and returns the result.
module me_job_ctrl
  import me_pkg::*;
#(
  parameter int  TB_LENGTH    = 16,
  parameter int  SW_LENGTH    = 64,
  parameter int  PE_OUT_WIDTH = 8,
  localparam int ADDR_SW      = addr_w(SW_LENGTH),
  localparam int ADDR_TB      = addr_w(TB_LENGTH),
  localparam int CNT_WIDTH    = cnt_w(TB_LENGTH, SW_LENGTH),
  localparam int SAD_WIDTH    = sad_w(TB_LENGTH, PE_OUT_WIDTH),
  localparam int MV_WIDTH     = mv_w(TB_LENGTH, SW_LENGTH)
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [SAD_WIDTH-1:0]       threshold_in,
  output logic                       busy,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [7:0]                 s_data,
  output logic [ADDR_TB-1:0]         mem_addr_tb,
  output logic                       mem_wren_tb,
  output logic [7:0]                 mem_data_tb,
  output logic [ADDR_SW-1:0]         mem_addr_sw,
  output logic                       mem_wren_sw,
  output logic [7:0]                 mem_data_sw,
  input  logic [ADDR_TB-1:0]         me_addr_tb,
  input  logic [ADDR_SW-1:0]         me_addr_sw,
  output logic                       me_req,
  output logic [SAD_WIDTH-1:0]       me_threshold,
  input  logic                       me_ack,
  input  logic [SAD_WIDTH-1:0]       me_min_sad,
  input  logic [CNT_WIDTH-1:0]       me_min_mvec,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [SAD_WIDTH-1:0]       res_sad,
  output logic signed [MV_WIDTH-1:0] res_dx,
  output logic signed [MV_WIDTH-1:0] res_dy
);

  localparam logic [ADDR_SW-1:0] TB_LAST = ADDR_SW'(TB_LENGTH * TB_LENGTH - 1);
  localparam logic [ADDR_SW-1:0] SW_LAST = ADDR_SW'(SW_LENGTH * SW_LENGTH - 1);

  state_t                     r_state;
  logic [ADDR_SW-1:0]         r_cnt;
  logic [SAD_WIDTH-1:0]       r_sad;
  logic [CNT_WIDTH-1:0]       r_mvec;
  logic                       w_load, w_beat, w_go, w_dec_done;
  logic signed [MV_WIDTH-1:0] w_dx, w_dy;

  // The loader owns both memory ports only while streaming; otherwise
  // me_top's read addresses pass straight through.
  assign w_load      = (r_state == S_LOAD_TB) || (r_state == S_LOAD_SW);
  assign w_beat      = s_valid && s_ready;
  assign w_go        = (r_state == S_REL) && !me_ack;
  assign mem_addr_tb = w_load ? r_cnt[ADDR_TB-1:0] : me_addr_tb;
  assign mem_addr_sw = w_load ? r_cnt : me_addr_sw;
  assign mem_wren_tb = (r_state == S_LOAD_TB) && w_beat;
  assign mem_wren_sw = (r_state == S_LOAD_SW) && w_beat;
  assign mem_data_tb = s_data;
  assign mem_data_sw = s_data;

  mvec_decode #(.TB_LENGTH(TB_LENGTH), .SW_LENGTH(SW_LENGTH)) u_dec (
    .clk    (clk),
    .rst    (rst),
    .i_go   (w_go),
    .i_mvec (r_mvec),
    .o_done (w_dec_done),
    .o_dx   (w_dx),
    .o_dy   (w_dy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_sad        <= '0;
      r_mvec       <= '0;
      busy         <= 1'b0;
      s_ready      <= 1'b0;
      me_req       <= 1'b0;
      me_threshold <= '0;
      res_valid    <= 1'b0;
      res_sad      <= '0;
      res_dx       <= '0;
      res_dy       <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          me_threshold <= threshold_in;
          r_cnt        <= '0;
          s_ready      <= 1'b1;
          busy         <= 1'b1;
          r_state      <= S_LOAD_TB;
        end
        S_LOAD_TB: if (w_beat) begin
          if (r_cnt == TB_LAST) begin
            r_cnt   <= '0;
            r_state <= S_LOAD_SW;
          end else begin
            r_cnt <= r_cnt + ADDR_SW'(1);
          end
        end
        S_LOAD_SW: if (w_beat) begin
          if (r_cnt == SW_LAST) begin
            s_ready <= 1'b0;
            me_req  <= 1'b1;
            r_state <= S_REQ;
          end else begin
            r_cnt <= r_cnt + ADDR_SW'(1);
          end
        end
        S_REQ: if (me_ack) begin
          r_sad   <= me_min_sad;
          r_mvec  <= me_min_mvec;
          me_req  <= 1'b0;
          r_state <= S_REL;
        end
        S_REL: if (!me_ack) r_state <= S_DECODE;
        S_DECODE: if (w_dec_done) begin
          res_sad   <= r_sad;
          res_dx    <= w_dx;
          res_dy    <= w_dy;
          res_valid <= 1'b1;
          r_state   <= S_OUT;
        end
        S_OUT: if (res_ready) begin
          res_valid <= 1'b0;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_me_job_ctrl.sv
// Bench for me_job_ctrl: stub search engine, behavioural pixel memories,
// decode table plus randomized jobs checked against plain div/mod.
module tb_me_job_ctrl;

  localparam int R   = 49;
  localparam int HR  = (R - 1) / 2;
  localparam int NTB = 256;
  localparam int NSW = 4096;

  logic        clk = 1'b0;
  logic        rst, start, s_valid, s_ready, busy, res_valid, res_ready;
  logic [15:0] threshold_in, me_threshold, me_min_sad, res_sad;
  logic [7:0]  s_data, mem_data_tb, mem_data_sw, mem_addr_tb, me_addr_tb;
  logic [11:0] mem_addr_sw, me_addr_sw, me_min_mvec;
  logic        mem_wren_tb, mem_wren_sw, me_req, me_ack;
  logic signed [6:0] res_dx, res_dy;

  always #5 clk = ~clk;

  me_job_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .threshold_in(threshold_in), .busy(busy),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mem_addr_tb(mem_addr_tb), .mem_wren_tb(mem_wren_tb), .mem_data_tb(mem_data_tb),
    .mem_addr_sw(mem_addr_sw), .mem_wren_sw(mem_wren_sw), .mem_data_sw(mem_data_sw),
    .me_addr_tb(me_addr_tb), .me_addr_sw(me_addr_sw),
    .me_req(me_req), .me_threshold(me_threshold), .me_ack(me_ack),
    .me_min_sad(me_min_sad), .me_min_mvec(me_min_mvec),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sad(res_sad), .res_dx(res_dx), .res_dy(res_dy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pixel memories and write monitor
  logic [7:0] mem_tb [NTB];
  logic [7:0] mem_sw [NSW];
  int wr_tb, wr_sw, err_tb, err_sw;
  logic clr_mon = 1'b0;

  always @(posedge clk) begin
    if (clr_mon) begin
      wr_tb <= 0; wr_sw <= 0; err_tb <= 0; err_sw <= 0;
    end else begin
      if (mem_wren_tb) begin
        mem_tb[mem_addr_tb] <= mem_data_tb;
        wr_tb <= wr_tb + 1;
        if (int'(mem_addr_tb) != wr_tb) err_tb <= err_tb + 1;
      end
      if (mem_wren_sw) begin
        mem_sw[mem_addr_sw] <= mem_data_sw;
        wr_sw <= wr_sw + 1;
        if (int'(mem_addr_sw) != wr_sw) err_sw <= err_sw + 1;
      end
    end
  end

  // Stub search engine: ack after ack_dly cycles of req, hold until req drops
  int          ack_dly = 5;
  int          dly;
  logic [15:0] stub_sad  = '0;
  logic [11:0] stub_mvec = '0;
  assign me_min_sad  = stub_sad;
  assign me_min_mvec = stub_mvec;

  always @(posedge clk) begin
    if (rst) begin
      me_ack <= 1'b0; dly <= 0;
    end else if (me_req && !me_ack) begin
      if (dly >= ack_dly) begin me_ack <= 1'b1; dly <= 0; end
      else dly <= dly + 1;
    end else if (!me_req && me_ack) begin
      me_ack <= 1'b0;
    end
  end

  logic [7:0] sw_img [NSW];
  logic [7:0] tb_img [NTB];

  // SW random; TB is the SW patch at the candidate the index names
  task automatic build_stream(input int mvec);
    int row, col;
    row = mvec / R;
    col = mvec % R;
    for (int i = 0; i < NSW; i++) sw_img[i] = 8'($urandom);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        tb_img[y*16+x] = sw_img[(row+y)*64 + col + x];
  endtask

  task automatic start_job(input logic [15:0] thr);
    start = 1'b1; threshold_in = thr; clr_mon = 1'b1;
    @(negedge clk);
    start = 1'b0; clr_mon = 1'b0; threshold_in = 16'($urandom);
    check("busy_on_start", busy, 1);
    check("s_ready_on_start", s_ready, 1);
  endtask

  // mode 0: always valid, 1: every other cycle, 2: random 75%
  task automatic load_stream(input int mode);
    int idx, cyc;
    logic v, rdy;
    idx = 0; cyc = 0;
    while (idx < NTB + NSW && cyc < 20000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      s_valid = v;
      s_data  = (idx < NTB) ? tb_img[idx] : sw_img[idx - NTB];
      rdy = s_ready;
      @(posedge clk);
      if (v && rdy) idx++;
      cyc++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    check("beats_consumed", idx, NTB + NSW);
    if (mode == 0) check("no_bubble_cycles", cyc, NTB + NSW);
  endtask

  task automatic finish_job(input logic [15:0] thr, input logic [15:0] exp_sad,
                            input int exp_dx, input int exp_dy, input int exp_cyc,
                            input int hold);
    int guard, n, chg;
    bit seen, rq;
    logic [15:0] s0, t0;
    logic signed [6:0] x0, y0;
    check("req_after_last_beat", me_req, 1);
    check("s_ready_after_load", s_ready, 0);
    check("me_threshold", me_threshold, thr);
    // Beats offered now must not be consumed
    s_valid = 1'b1; s_data = 8'($urandom);
    me_addr_tb = 8'($urandom); me_addr_sw = 12'($urandom);
    #1;
    check("addr_sw_passthru", mem_addr_sw, me_addr_sw);
    check("addr_tb_passthru", mem_addr_tb, me_addr_tb);
    check("wren_sw_idle", mem_wren_sw, 0);
    guard = 0; n = 0; seen = 0; rq = 0;
    while (guard < 500) begin
      @(negedge clk);
      guard++;
      if (res_valid) break;
      if (me_ack) begin
        if (seen && !rq) begin check("req_drop_after_ack", me_req, 0); rq = 1; end
        seen = 1;
      end else if (seen) begin
        n++;
      end
    end
    check("res_valid_seen", res_valid, 1);
    // n counts the cycle after ack falls plus every DECODE cycle
    check("decode_cycles", n - 1, exp_cyc);
    check("res_sad", res_sad, exp_sad);
    check("res_dx", res_dx, exp_dx);
    check("res_dy", res_dy, exp_dy);
    s0 = res_sad; x0 = res_dx; y0 = res_dy; t0 = me_threshold; chg = 0;
    for (int i = 0; i < hold; i++) begin
      start = 1'($urandom); threshold_in = 16'($urandom);
      @(negedge clk);
      if (res_sad !== s0 || res_dx !== x0 || res_dy !== y0 || me_threshold !== t0 ||
          !res_valid || !busy || s_ready) chg++;
    end
    start = 1'b0; s_valid = 1'b0;
    check("stall_fields_stable", chg, 0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("busy_after_accept", busy, 0);
    check("valid_after_accept", res_valid, 0);
  endtask

  task automatic check_mem();
    int m_tb, m_sw;
    m_tb = 0; m_sw = 0;
    for (int i = 0; i < NTB; i++) if (mem_tb[i] !== tb_img[i]) m_tb++;
    for (int i = 0; i < NSW; i++) if (mem_sw[i] !== sw_img[i]) m_sw++;
    check("tb_write_count", wr_tb, NTB);
    check("sw_write_count", wr_sw, NSW);
    check("tb_addr_contig_err", err_tb, 0);
    check("sw_addr_contig_err", err_sw, 0);
    check("tb_mem_dump_mism", m_tb, 0);
    check("sw_mem_dump_mism", m_sw, 0);
  endtask

  task automatic full_job(input int mvec, input int sad, input int thr, input int mode,
                          input int ackd, input int exp_dx, input int exp_dy,
                          input int exp_cyc, input int hold);
    build_stream(mvec);
    stub_mvec = 12'(mvec); stub_sad = 16'(sad); ack_dly = ackd;
    start_job(16'(thr));
    load_stream(mode);
    finish_job(16'(thr), 16'(sad), exp_dx, exp_dy, exp_cyc, hold);
    check_mem();
  endtask

  typedef struct {
    int mvec; int sad; int thr; int dx; int dy; int cyc;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mv;
    tbl[0] = '{0,    1234, 100,  -24, -24, 1};
    tbl[1] = '{2400, 77,   9000,  24,  24, 49};
    tbl[2] = '{1200, 5,    321,    0,   0, 25};
    tbl[3] = '{48,   65535, 1,    24, -24, 1};
    tbl[4] = '{520,  0,    4000,   6, -14, 11};

    // Reset with random inputs
    rst = 1'b1; res_ready = 1'b0; s_valid = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom); s_valid = 1'($urandom); s_data = 8'($urandom);
      threshold_in = 16'($urandom); res_ready = 1'($urandom);
      me_addr_tb = 8'($urandom); me_addr_sw = 12'($urandom);
      @(negedge clk);
    end
    check("rst_flags", {s_ready, busy, me_req, res_valid, mem_wren_tb, mem_wren_sw}, 0);
    check("rst_threshold", me_threshold, 0);
    check("rst_res_sad", res_sad, 0);
    check("rst_res_dx", res_dx, 0);
    check("rst_res_dy", res_dy, 0);
    check("rst_addr_tb_follow", mem_addr_tb, me_addr_tb);
    check("rst_addr_sw_follow", mem_addr_sw, me_addr_sw);
    rst = 1'b0; start = 1'b0; s_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);

    // Decode corners and the reference full job, back to back
    for (int i = 0; i < 5; i++)
      full_job(tbl[i].mvec, tbl[i].sad, tbl[i].thr, 0, 5,
               tbl[i].dx, tbl[i].dy, tbl[i].cyc, 0);

    // Stalled stream plus 20 cycles of result back-pressure
    mv = $urandom_range(0, R*R - 1);
    full_job(mv, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 1, 3,
             mv % R - HR, mv / R - HR, mv / R + 1, 20);

    // Randomized jobs against div/mod model
    for (int j = 0; j < 2; j++) begin
      mv = $urandom_range(0, R*R - 1);
      full_job(mv, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 2,
               int'($urandom_range(0, 8)), mv % R - HR, mv / R - HR, mv / R + 1,
               int'($urandom_range(0, 5)));
    end

    // Reset while waiting for ack, then a clean job
    build_stream(700);
    ack_dly = 5;
    start_job(16'd42);
    load_stream(0);
    check("req_before_reset", me_req, 1);
    rst = 1'b1;
    @(negedge clk);
    check("req_after_reset", me_req, 0);
    check("busy_after_reset", busy, 0);
    check("flags_after_reset", {s_ready, res_valid}, 0);
    check("thr_after_reset", me_threshold, 0);
    rst = 1'b0;
    @(negedge clk);
    full_job(520, 0, 4000, 0, 5, 6, -14, 11, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/me_job_ctrl.md
# me_job_ctrl

Job sequencer directly upstream of `me_top`. It loads one template block (TB) and one search window (SW) from a byte stream into the two single-port pixel memories, then runs a four-phase req/ack handshake with `me_top`. It captures `min_sad`/`min_mvec`, decodes the linear vector index into signed (dx, dy) and presents the result on a valid/ready port. It owns the memory address/write muxing between loading and searching.

## Interface
Parameters:
- `TB_LENGTH`, 16, template block side in pixels
- `SW_LENGTH`, 64, search window side in pixels
- `PE_OUT_WIDTH`, 8, PE difference width; must match `me_top`

Derived: `ADDR_SW=$clog2(SW_LENGTH**2)`, `ADDR_TB=$clog2(TB_LENGTH**2)`, `R=SW_LENGTH-TB_LENGTH+1`, `CNT_WIDTH=$clog2(R**2)`, `SAD_WIDTH=$clog2(TB_LENGTH**2)+PE_OUT_WIDTH`, `MV_WIDTH=$clog2(R)+1` (signed).

Ports:
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — synchronous, active-high reset
- `start` in 1 — job request; accepted only in IDLE
- `threshold_in` in SAD_WIDTH — sampled on accepted `start`
- `busy` out 1 — high in every state except IDLE
- `s_valid` in 1, `s_ready` out 1, `s_data` in 8 — pixel stream, raster order: TB pixels first, then SW pixels
- `mem_addr_tb` out ADDR_TB, `mem_wren_tb` out 1, `mem_data_tb` out 8 — TB memory port
- `mem_addr_sw` out ADDR_SW, `mem_wren_sw` out 1, `mem_data_sw` out 8 — SW memory port
- `me_addr_tb` in ADDR_TB, `me_addr_sw` in ADDR_SW — read addresses from `me_top`
- `me_req` out 1, `me_threshold` out SAD_WIDTH, `me_ack` in 1 — handshake to `me_top`
- `me_min_sad` in SAD_WIDTH, `me_min_mvec` in CNT_WIDTH — results from `me_top`
- `res_valid` out 1, `res_ready` in 1 — result handshake
- `res_sad` out SAD_WIDTH, `res_dx` out MV_WIDTH, `res_dy` out MV_WIDTH — result fields

## Operation
- States: IDLE, LOAD_TB, LOAD_SW, REQ, REL, DECODE, OUT.
- IDLE: `start`=1 → latch `threshold_in` into `me_threshold`, clear load counter, go to LOAD_TB.
- LOAD_TB: `s_ready`=1. Each beat (`s_valid&&s_ready`) drives `mem_wren_tb`=1, `mem_data_tb`=`s_data`, `mem_addr_tb`=counter combinationally in the same cycle, then the counter increments. After beat TB_LENGTH²-1 (beat 255), clear the counter and go to LOAD_SW.
- LOAD_SW: same behaviour on the SW port. After beat SW_LENGTH²-1 (beat 4095), go to REQ.
- REQ: `me_req`=1. On `me_ack`=1, register `me_min_sad` and `me_min_mvec`, then go to REL.
- REL: `me_req`=0. Wait for `me_ack`=0, then go to DECODE.
- DECODE: restoring division of the captured mvec by R. One subtract per cycle while rem≥R; row increments per subtract. When rem<R: `res_dy`=row−(R−1)/2, `res_dx`=rem−(R−1)/2, `res_sad`=captured SAD; go to OUT.
- OUT: `res_valid`=1 with fields stable. On `res_ready`=1, go to IDLE.
- Address mux: in LOAD_TB/LOAD_SW the loader drives the memory addresses; in every other state `mem_addr_*` = `me_addr_*` and `mem_wren_*`=0.
- `s_ready`=0 outside the load states. Beats presented then are not consumed.
- `start` is ignored while `busy`.
- mvec is row-major: mvec = row·R + col, with row 0 / col 0 the top-left candidate.

## Timing
- Reset values: `s_ready`, `mem_wren_*`, `me_req`, `res_valid`, `busy`=0; `me_threshold`, `res_sad`, `res_dx`, `res_dy`=0; state IDLE.
- `start` accepted at edge t → `s_ready`=1 and `busy`=1 from cycle t+1.
- Writes are combinational from accepted beats; there is zero bubble between the TB and SW phases.
- Last SW beat at edge t → `me_req`=1 from t+1.
- `me_ack` seen at edge t → `me_req`=0 from t+1, and results are captured at t.
- `me_ack` low at edge t → DECODE entered at t+1. DECODE lasts row+1 cycles (max R cycles).
- `res_valid` held until accepted. An accept at edge t gives `busy`=0 at t+1; a new `start` can be accepted at t+1.
- `rst` mid-job: all outputs return to reset values on the next edge. Partial memory contents are not cleared.

## Structure
- Package `me_pkg`: width helper functions (ADDR_SW/TB, CNT_WIDTH, SAD_WIDTH, MV_WIDTH) and the state enum constants.
- Sub-module `mvec_decode`: sequential divide/offset with `go`/`done`, instantiated from the DECODE state.

## Test plan
- Reset: hold `rst` 3 cycles with random inputs → every output at its reset value; `mem_addr_*` follows `me_addr_*`.
- Full job, real `me_top` plus two `memory_single_port` instances: SW = pseudo-random, TB = SW copy at row 10, col 30, threshold 4000 → `res_sad`=0, `res_dy`=−14, `res_dx`=+6.
- Stalled stream: `s_valid` toggles every other cycle → exactly 256 TB and 4096 SW writes at contiguous addresses 0..N−1; memory dump matches the stream.
- Decode corners with a stub `me_top` (ack 5 cycles after req): mvec 0 → (−24,−24); 2400 → (24,24); 1200 → (0,0); 48 → dx=24, dy=−24. DECODE cycle counts are 1, 49, 25, 1.
- Back-pressure and busy: `res_ready` low for 20 cycles → fields stable, `start` pulses ignored; after accept, a new job starts the next cycle.
- Reset in REQ: `me_req` falls on the following edge, state IDLE, then a subsequent full job completes correctly.
